// File: rtl/dadda_pkg.sv
// Shared widths, FSM state type and a CHUNK_W legality helper for the Dadda final adder.
package dadda_pkg;

  localparam int ROW_W = 16;
  localparam int RES_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit chunk_w_legal(input int w);
    return (w >= 1) && (w <= ROW_W) && ((ROW_W % w) == 0);
  endfunction

endpackage

// File: rtl/dadda_final_adder_chunk_adder.sv
// Combinational W-bit slice adder with carry in and carry out.
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);

endmodule

// File: rtl/dadda_final_adder.sv
// Sequential carry-chained final adder for two Dadda rows, one CHUNK_W slice per cycle.
// Optional macro DADDA_FA_ZERO_FLAG_EN adds a registered res_zero output.
module dadda_final_adder
  import dadda_pkg::*;
#(
  parameter int CHUNK_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] row0,
  input  logic [ROW_W-1:0] row1,
  output logic [RES_W-1:0] res,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DADDA_FA_ZERO_FLAG_EN
  ,
  output logic             res_zero
`endif
);

  localparam int N     = ROW_W / CHUNK_W;
  localparam int IDX_W = $clog2(N + 1);

  if (!chunk_w_legal(CHUNK_W)) begin : g_bad_chunk_w
    $error("dadda_final_adder: CHUNK_W must divide 16");
  end

  state_t             state_reg;
  logic [ROW_W-1:0]   row0_reg;
  logic [ROW_W-1:0]   row1_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [RES_W-1:0]   res_reg;
  logic               out_valid_reg;
  logic               in_ready_reg;

  logic [CHUNK_W-1:0] a_slices [N];
  logic [CHUNK_W-1:0] b_slices [N];
  logic [CHUNK_W-1:0] slice_a;
  logic [CHUNK_W-1:0] slice_b;
  logic [CHUNK_W-1:0] slice_sum;
  logic               slice_cout;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign a_slices[gi] = row0_reg[gi*CHUNK_W +: CHUNK_W];
      assign b_slices[gi] = row1_reg[gi*CHUNK_W +: CHUNK_W];
    end
  endgenerate

  // idx_reg == N is the carry-finalisation step; no slice is selected then.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        slice_a = a_slices[i];
        slice_b = b_slices[i];
      end
    end
  end

  chunk_adder #(.W(CHUNK_W)) u_chunk (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

`ifdef DADDA_FA_ZERO_FLAG_EN
  logic res_zero_reg;
  assign res_zero = res_zero_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      res_reg       <= '0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      row0_reg      <= '0;
      row1_reg      <= '0;
`ifdef DADDA_FA_ZERO_FLAG_EN
      res_zero_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            row0_reg     <= row0;
            row1_reg     <= row1;
            carry_reg    <= 1'b0;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= ADD;
          end
        end
        ADD: begin
          if (idx_reg == IDX_W'(N)) begin
            res_reg[RES_W-1] <= carry_reg;
            out_valid_reg    <= 1'b1;
            state_reg        <= DONE;
`ifdef DADDA_FA_ZERO_FLAG_EN
            res_zero_reg     <= !carry_reg && (res_reg[ROW_W-1:0] == '0);
`endif
          end else begin
            for (int i = 0; i < N; i++) begin
              if (idx_reg == IDX_W'(i)) begin
                res_reg[i*CHUNK_W +: CHUNK_W] <= slice_sum;
              end
            end
            carry_reg <= slice_cout;
            idx_reg   <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign res       = res_reg;

endmodule

// File: tb/tb_dadda_final_adder.sv
// Bench for dadda_final_adder: three instances (CHUNK_W 4, 1, 16) checked against a latency/sum model.
module tb_dadda_final_adder;

  localparam int NI = 3;

  function automatic int cw_of(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [15:0] row0      [NI];
  logic [15:0] row1      [NI];
  logic [16:0] res       [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
`ifdef DADDA_FA_ZERO_FLAG_EN
  logic        res_zero  [NI];
`endif

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      dadda_final_adder #(.CHUNK_W(cw_of(gi))) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .row0      (row0[gi]),
        .row1      (row1[gi]),
        .res       (res[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi])
`ifdef DADDA_FA_ZERO_FLAG_EN
        ,
        .res_zero  (res_zero[gi])
`endif
      );
    end
  endgenerate

  // Reference: the result is the plain 17-bit sum, visible 16/CHUNK_W+1 edges after accept.
  logic        m_init = 1'b0;
  logic        m_ready [NI];
  logic        m_valid [NI];
  logic        m_busy  [NI];
  logic [16:0] m_res   [NI];
  logic [16:0] m_pend  [NI];
  int          m_cnt   [NI];

  always @(posedge clk) begin
    if (rst) m_init <= 1'b1;
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        m_ready[g] <= 1'b1;
        m_valid[g] <= 1'b0;
        m_busy[g]  <= 1'b0;
        m_res[g]   <= '0;
        m_cnt[g]   <= 0;
      end else if (m_ready[g]) begin
        if (in_valid[g]) begin
          m_ready[g] <= 1'b0;
          m_busy[g]  <= 1'b1;
          m_pend[g]  <= {1'b0, row0[g]} + {1'b0, row1[g]};
          m_cnt[g]   <= 16 / cw_of(g) + 1;
        end
      end else if (m_busy[g]) begin
        m_cnt[g] <= m_cnt[g] - 1;
        if (m_cnt[g] == 1) begin
          m_busy[g]  <= 1'b0;
          m_valid[g] <= 1'b1;
          m_res[g]   <= m_pend[g];
        end
      end else if (m_valid[g] && out_ready[g]) begin
        m_valid[g] <= 1'b0;
        m_ready[g] <= 1'b1;
      end
    end
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  int          timeout_count = 0;
  int          timeout_seen = 0;
  logic [16:0] lit_q [$];

  task automatic check(input string name, input int g, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", name, g, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [16:0] lit;
    if (timeout_count != timeout_seen) begin
      check("wait_timeout", 0, 17'(timeout_count), 17'(timeout_seen));
      timeout_seen = timeout_count;
    end
    if (m_init) begin
      for (int g = 0; g < NI; g++) begin
        check("in_ready", g, 17'(in_ready[g]), 17'(m_ready[g]));
        check("out_valid", g, 17'(out_valid[g]), 17'(m_valid[g]));
        if (!m_busy[g]) check("res", g, res[g], m_res[g]);
`ifdef DADDA_FA_ZERO_FLAG_EN
        if (m_valid[g]) check("res_zero", g, 17'(res_zero[g]), 17'(m_res[g] == 17'd0));
`endif
        if (out_valid[g] && out_ready[g] && !rst) begin
          $display("xfer inst=%0d cw=%0d res=%h model=%h t=%0t", g, cw_of(g), res[g], m_res[g], $time);
          if (g == 0 && lit_q.size() > 0) begin
            lit = lit_q.pop_front();
            check("literal_res", g, res[g], lit);
            check("literal_model", g, m_res[g], lit);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input bit want_ready);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (want_ready ? in_ready[0] : out_valid[0]) break;
    end
    if (k == 60) timeout_count++;
  endtask

  task automatic do_pair(input logic [15:0] a, input logic [15:0] b, input logic [16:0] lit, input bit stall);
    lit_q.push_back(lit);
    row0[0] = a;
    row1[0] = b;
    in_valid[0] = 1'b1;
    out_ready[0] = !stall;
    wait_neg(1'b1);
    tick();
    in_valid[0] = 1'b0;
    row0[0] = 16'($urandom);
    row1[0] = 16'($urandom);
    if (stall) begin
      wait_neg(1'b0);
      repeat (10) begin
        tick();
        row0[0] = 16'($urandom);
      end
      out_ready[0] = 1'b1;
    end
    wait_neg(1'b0);
    tick();
    tick();
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b1;
      row0[g] = '0;
      row1[g] = '0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    do_pair(16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b0);
    do_pair(16'h00FF, 16'h0001, 17'h00100, 1'b0);
    do_pair(16'h1234, 16'h4321, 17'h05555, 1'b1);

    // Abort an operation with a reset during its second ADD cycle.
    row0[0] = 16'h1234;
    row1[0] = 16'h5678;
    in_valid[0] = 1'b1;
    wait_neg(1'b1);
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    do_pair(16'h0001, 16'h0001, 17'h00002, 1'b0);
`ifdef DADDA_FA_ZERO_FLAG_EN
    do_pair(16'h0000, 16'h0000, 17'h00000, 1'b0);
    do_pair(16'h8000, 16'h8000, 17'h10000, 1'b0);
`endif

    // Back-to-back on every instance; rows churn every cycle.
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b1;
      out_ready[g] = 1'b1;
    end
    repeat (100) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        row0[g] = 16'($urandom);
        row1[g] = 16'($urandom);
      end
    end

    // Fully random handshakes with occasional resets.
    repeat (500) begin
      tick();
      rst = ($urandom_range(0, 149) == 0);
      for (int g = 0; g < NI; g++) begin
        in_valid[g] = 1'($urandom);
        out_ready[g] = ($urandom_range(0, 3) != 0);
        row0[g] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        row1[g] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      end
    end
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b1;
    end
    repeat (30) tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
